// File: rtl/memory_tank_controller_if.sv
// ============================================================================
// memory_tank_controller_if
// ----------------------------------------------------------------------------
// Purpose : Store-control side of the long-tank sequencer. Groups the access
//           request, the serial data pair and the status/handshake strobes.
//
// Signals : req          access request (level)
//           we           1 = write, 0 = read
//           long_w       1 = 35-bit long word, 0 = 17-bit short word
//           addr         short-word location (minor cycle)
//           clr          clear-whole-tank request
//           wdata        serial write bit, LSB first
//           rdata        serial read bit, LSB first
//           rdata_valid  read bit strobe
//           wdata_req    write bit consumed this cycle
//           busy         sequencer not idle
//           ack          one-cycle completion pulse
//
// Modports: master = store control, slave = tank controller
// ============================================================================
interface memory_tank_controller_if #(
    parameter int ADDR_W = 5
);
    logic              req;
    logic              we;
    logic              long_w;
    logic [ADDR_W-1:0] addr;
    logic              clr;
    logic              wdata;
    logic              rdata;
    logic              rdata_valid;
    logic              wdata_req;
    logic              busy;
    logic              ack;

    modport master (
        output req, we, long_w, addr, clr, wdata,
        input  rdata, rdata_valid, wdata_req, busy, ack
    );

    modport slave (
        input  req, we, long_w, addr, clr, wdata,
        output rdata, rdata_valid, wdata_req, busy, ack
    );
endinterface

// File: rtl/memory_tank_controller.sv
// ============================================================================
// memory_tank_controller
// ----------------------------------------------------------------------------
// Purpose : Sequencer for one recirculating long tank of MINORS minor cycles x
//           BITS_PER_MINOR pulse positions. Free-running bit/minor counters
//           name the location currently emerging from the delay line. The tank
//           input recirculates the output by default; an accepted request
//           waits for the addressed word to emerge and then gates a serial
//           read or write, or a clear of the whole tank.
//
// Ports   : i_r1_clk      bit-rate clock, one pulse position per cycle
//           i_r1_rst      synchronous reset, active-high
//           io_bus        store-control interface (slave modport)
//           i_tank_out    bit emerging from the delay line this cycle
//           o_tank_in     bit fed into the delay line
//           o_minor_sync  high when bit_cnt == 0
//           o_minor_cnt   current minor cycle at the tank output
//           o_bit_cnt     current pulse position, 0..BITS_PER_MINOR-1
// ============================================================================
module memory_tank_controller #(
    parameter int BITS_PER_MINOR = 18,
    parameter int MINORS         = 32,
    parameter int ADDR_W         = 5
) (
    input  logic                      i_r1_clk,
    input  logic                      i_r1_rst,
    memory_tank_controller_if.slave   io_bus,
    input  logic                      i_tank_out,
    output logic                      o_tank_in,
    output logic                      o_minor_sync,
    output logic [ADDR_W-1:0]         o_minor_cnt,
    output logic [4:0]                o_bit_cnt
);

    localparam logic [4:0]        LAST_BIT       = 5'(BITS_PER_MINOR - 1);
    localparam logic [4:0]        LAST_SHORT_BIT = 5'(BITS_PER_MINOR - 2);
    localparam logic [ADDR_W-1:0] LAST_MINOR     = ADDR_W'(MINORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_CLR_WAIT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [4:0]         r_bit_cnt;
    logic [ADDR_W-1:0]  r_minor_cnt;
    logic               r_we;
    logic               r_long;
    logic [ADDR_W-1:0]  r_tgt;

    logic               w_wrap;
    logic [ADDR_W-1:0]  w_next_minor;
    logic [ADDR_W-1:0]  w_req_tgt;
    logic               w_accept;
    logic               w_hit_req;
    logic               w_hit_tgt;
    logic               w_hit_zero;
    logic               w_xfer_last;
    logic               w_clear_last;

    logic               w_tank_in;
    logic               w_rdata;
    logic               w_rdata_valid;
    logic               w_wdata_req;
    logic               w_busy;
    logic               w_ack;
    logic               w_minor_sync;

    // ------------------------------------------------------------------------
    // Tank position counters
    // ------------------------------------------------------------------------
    assign w_wrap       = (r_bit_cnt == LAST_BIT);
    assign w_next_minor = (r_minor_cnt == LAST_MINOR) ? '0 : r_minor_cnt + 1'b1;

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge i_r1_clk) begin
        if (i_r1_rst) begin
            r_bit_cnt   <= '0;
            r_minor_cnt <= '0;
        end else if (w_wrap) begin
            r_bit_cnt   <= '0;
            r_minor_cnt <= w_next_minor;
        end else begin
            r_bit_cnt   <= r_bit_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Position matching. The sequencer looks one cycle ahead: the state moves
    // to XFER/CLEAR on the edge that brings the target location to the tank
    // output, so the matching cycle itself carries the first bit. Matching
    // the next position (never the current one) also makes a request accepted
    // exactly at the target wait a full major cycle.
    // ------------------------------------------------------------------------
    assign w_req_tgt    = io_bus.long_w ? {io_bus.addr[ADDR_W-1:1], 1'b0} : io_bus.addr;
    assign w_accept     = io_bus.req && !io_bus.clr;
    assign w_hit_req    = w_wrap && (w_next_minor == w_req_tgt);
    assign w_hit_tgt    = w_wrap && (w_next_minor == r_tgt);
    assign w_hit_zero   = w_wrap && (w_next_minor == '0);

    // A transfer starts at bit 0 of minor tgt. A short word ends at bit 16 of
    // that minor; a long word ends at bit 16 of the following minor.
    assign w_xfer_last  = (r_bit_cnt == LAST_SHORT_BIT) && (!r_long || (r_minor_cnt != r_tgt));

    // A clear starts at minor 0, bit 0 and therefore spans one full major cycle.
    assign w_clear_last = w_wrap && (r_minor_cnt == LAST_MINOR);

    // ------------------------------------------------------------------------
    // Request latch: the access parameters are frozen at acceptance
    // ------------------------------------------------------------------------
    always_ff @(posedge i_r1_clk) begin
        if (i_r1_rst) begin
            r_we   <= 1'b0;
            r_long <= 1'b0;
            r_tgt  <= '0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_we   <= io_bus.we;
            r_long <= io_bus.long_w;
            r_tgt  <= w_req_tgt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_r1_clk) begin
        if (i_r1_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, so no path through the case statement can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.clr) begin
                    w_state_next = w_hit_zero ? S_CLEAR : S_CLR_WAIT;
                end else if (io_bus.req) begin
                    w_state_next = w_hit_req ? S_XFER : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_hit_tgt) begin
                    w_state_next = S_XFER;
                end
            end
            S_XFER: begin
                if (w_xfer_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_CLR_WAIT: begin
                if (w_hit_zero) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (w_clear_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. Reset forces every 1-bit output low in the same cycle,
    // which also writes zeros into the tank while reset is held.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tank_in     = i_tank_out;
        w_rdata       = 1'b0;
        w_rdata_valid = 1'b0;
        w_wdata_req   = 1'b0;
        w_busy        = (r_state != S_IDLE);
        w_ack         = 1'b0;
        w_minor_sync  = (r_bit_cnt == '0);

        case (r_state)
            S_XFER: begin
                if (r_we) begin
                    w_wdata_req = 1'b1;
                    w_tank_in   = io_bus.wdata;
                end else begin
                    w_rdata_valid = 1'b1;
                    w_rdata       = i_tank_out;
                end
            end
            S_CLEAR: begin
                w_tank_in = 1'b0;
            end
            S_DONE: begin
                w_ack = 1'b1;
            end
            default: begin
            end
        endcase

        if (i_r1_rst) begin
            w_tank_in     = 1'b0;
            w_rdata       = 1'b0;
            w_rdata_valid = 1'b0;
            w_wdata_req   = 1'b0;
            w_busy        = 1'b0;
            w_ack         = 1'b0;
            w_minor_sync  = 1'b0;
        end
    end

    assign o_tank_in          = w_tank_in;
    assign o_minor_sync       = w_minor_sync;
    assign o_minor_cnt        = r_minor_cnt;
    assign o_bit_cnt          = r_bit_cnt;
    assign io_bus.rdata       = w_rdata;
    assign io_bus.rdata_valid = w_rdata_valid;
    assign io_bus.wdata_req   = w_wdata_req;
    assign io_bus.busy        = w_busy;
    assign io_bus.ack         = w_ack;

endmodule

// File: tb/tb_memory_tank_controller.sv
// ============================================================================
// tb_memory_tank_controller
// ----------------------------------------------------------------------------
// Purpose : Directed bench for memory_tank_controller. A 576-bit shift
//           register stands in for the delay line (tank_in re-emerges on
//           tank_out exactly 576 cycles later), and an independent pair of
//           counters tracks the expected tank position.
// ============================================================================
module tb_memory_tank_controller;

    logic        clk = 1'b0;
    logic        r1_rst;
    logic        tank_in;
    logic        tank_out;
    logic        minor_sync;
    logic [4:0]  minor_cnt;
    logic [4:0]  bit_cnt;

    memory_tank_controller_if #(.ADDR_W(5)) bus ();

    memory_tank_controller #(
        .BITS_PER_MINOR(18),
        .MINORS        (32),
        .ADDR_W        (5)
    ) dut (
        .i_r1_clk    (clk),
        .i_r1_rst    (r1_rst),
        .io_bus      (bus),
        .i_tank_out  (tank_out),
        .o_tank_in   (tank_in),
        .o_minor_sync(minor_sync),
        .o_minor_cnt (minor_cnt),
        .o_bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // Delay line model; 'fill' preloads every position with 1
    logic [575:0] sr   = '0;
    logic         fill = 1'b0;
    always @(posedge clk) begin
        if (fill) sr <= '1;
        else      sr <= {sr[574:0], tank_in};
    end
    assign tank_out = sr[575];

    // Expected tank position
    int m_bit = 0;
    int m_min = 0;
    always @(posedge clk) begin
        if (r1_rst) begin
            m_bit <= 0;
            m_min <= 0;
        end else if (m_bit == 17) begin
            m_bit <= 0;
            m_min <= (m_min + 1) % 32;
        end else begin
            m_bit <= m_bit + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the last access
    logic [34:0] res_rd;
    int          res_n, res_lat, res_min, res_bit, res_gap, res_zc, res_zmin, res_zbit;
    logic        res_ack;

    // Advance to the middle of the next cycle (registers settled)
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Step until the expected position is (mn, bt); always at least one step
    task automatic wait_pos(input int mn, input int bt);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(m_min == mn && m_bit == bt) && k < 700);
    endtask

    // One access: the current cycle is the accept cycle (c = 0). Inputs are
    // scrambled after acceptance; returns one cycle after ack (DUT idle).
    task automatic access(input logic i_we, input logic i_long, input logic [4:0] i_addr,
                          input logic [34:0] i_wd, input logic i_clr);
        int last;
        last = 0;
        res_rd = '0; res_n = 0; res_lat = -1; res_min = -1; res_bit = -1; res_gap = -1;
        res_zc = 0; res_zmin = -1; res_zbit = -1; res_ack = 1'b0;
        bus.req = 1'b1; bus.we = i_we; bus.long_w = i_long; bus.addr = i_addr; bus.clr = i_clr;
        for (int c = 1; c <= 1300 && !res_ack; c++) begin
            step();
            if (c == 1) begin
                bus.req = 1'b0; bus.clr = 1'b0;
                bus.we = ~i_we; bus.long_w = ~i_long; bus.addr = ~i_addr;
            end
            bus.wdata = (bus.wdata_req && res_n < 35) ? i_wd[res_n] : 1'b1;
            #1;
            if (bus.wdata_req || bus.rdata_valid) begin
                if (res_n == 0) begin
                    res_lat = c; res_min = m_min; res_bit = m_bit;
                end
                if (bus.rdata_valid && res_n < 35) res_rd[res_n] = bus.rdata;
                res_n++;
                last = c;
            end
            if (tank_in === 1'b0 && tank_out === 1'b1) begin
                if (res_zc == 0) begin
                    res_zmin = m_min; res_zbit = m_bit;
                end
                res_zc++;
            end
            if (bus.ack === 1'b1) begin
                res_ack = 1'b1;
                res_gap = c - last;
            end
        end
        bus.we = 1'b0; bus.long_w = 1'b0; bus.addr = '0;
        step();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        repeat (23) step();
        n_tests++; if (bit_cnt !== 5'd5) begin n_fail++; $display("FAIL rst_pre_bit: got %0d exp 5", bit_cnt); end
        n_tests++; if (minor_cnt !== 5'd1) begin n_fail++; $display("FAIL rst_pre_minor: got %0d exp 1", minor_cnt); end
        r1_rst = 1'b1;
        step();
        #1;
        n_tests++; if (bit_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_bit: got %0d exp 0", bit_cnt); end
        n_tests++; if (minor_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_minor: got %0d exp 0", minor_cnt); end
        n_tests++;
        if ({minor_sync, tank_in, bus.rdata, bus.rdata_valid, bus.wdata_req, bus.busy, bus.ack} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_outputs: got %b exp 0000000",
                     {minor_sync, tank_in, bus.rdata, bus.rdata_valid, bus.wdata_req, bus.busy, bus.ack});
        end
        step();
        step();
        r1_rst = 1'b0;
        #1;
        n_tests++; if (minor_sync !== 1'b1) begin n_fail++; $display("FAIL rst_release_sync: got %b exp 1", minor_sync); end
        repeat (17) step();
        n_tests++; if ({minor_cnt, bit_cnt} !== {5'd0, 5'd17}) begin n_fail++; $display("FAIL rst_cnt17: got %0d/%0d exp 0/17", minor_cnt, bit_cnt); end
        step();
        n_tests++; if ({minor_cnt, bit_cnt} !== {5'd1, 5'd0}) begin n_fail++; $display("FAIL rst_cnt18: got %0d/%0d exp 1/0", minor_cnt, bit_cnt); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_short();
        fill = 1'b1;
        step();
        fill = 1'b0;
        access(1'b1, 1'b0, 5'd5, 35'h1A5C3, 1'b0);
        n_tests++; if (res_ack !== 1'b1) begin n_fail++; $display("FAIL short_wr_ack: got %b exp 1", res_ack); end
        n_tests++; if (res_n !== 17) begin n_fail++; $display("FAIL short_wr_len: got %0d exp 17", res_n); end
        n_tests++; if (res_min !== 5 || res_bit !== 0) begin n_fail++; $display("FAIL short_wr_start: got %0d/%0d exp 5/0", res_min, res_bit); end
        n_tests++; if (res_gap !== 1) begin n_fail++; $display("FAIL short_wr_ack_gap: got %0d exp 1", res_gap); end
        access(1'b0, 1'b0, 5'd5, 35'h0, 1'b0);
        n_tests++; if (res_rd[16:0] !== 17'h1A5C3) begin n_fail++; $display("FAIL short_rd_data: got %h exp 1a5c3", res_rd[16:0]); end
        n_tests++; if (res_n !== 17) begin n_fail++; $display("FAIL short_rd_len: got %0d exp 17", res_n); end
        access(1'b0, 1'b0, 5'd4, 35'h0, 1'b0);
        n_tests++; if (res_rd[16:0] !== 17'h1FFFF) begin n_fail++; $display("FAIL short_rd_addr4: got %h exp 1ffff", res_rd[16:0]); end
        access(1'b0, 1'b0, 5'd6, 35'h0, 1'b0);
        n_tests++; if (res_rd[16:0] !== 17'h1FFFF) begin n_fail++; $display("FAIL short_rd_addr6: got %h exp 1ffff", res_rd[16:0]); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_long();
        access(1'b1, 1'b1, 5'd7, 35'h5_A5A5_A5A5, 1'b0);
        n_tests++; if (res_min !== 6 || res_bit !== 0) begin n_fail++; $display("FAIL long_wr_start: got %0d/%0d exp 6/0", res_min, res_bit); end
        n_tests++; if (res_n !== 35) begin n_fail++; $display("FAIL long_wr_len: got %0d exp 35", res_n); end
        n_tests++; if (res_ack !== 1'b1 || res_gap !== 1) begin n_fail++; $display("FAIL long_wr_ack: got %b gap %0d exp 1 gap 1", res_ack, res_gap); end
        access(1'b0, 1'b1, 5'd6, 35'h0, 1'b0);
        n_tests++; if (res_rd !== 35'h5_A5A5_A5A5) begin n_fail++; $display("FAIL long_rd_data: got %h exp 5a5a5a5a5", res_rd); end
        n_tests++; if (res_n !== 35) begin n_fail++; $display("FAIL long_rd_len: got %0d exp 35", res_n); end
        access(1'b0, 1'b0, 5'd5, 35'h0, 1'b0);
        n_tests++; if (res_rd[16:0] !== 17'h1A5C3) begin n_fail++; $display("FAIL long_keeps_addr5: got %h exp 1a5c3", res_rd[16:0]); end
        access(1'b0, 1'b0, 5'd8, 35'h0, 1'b0);
        n_tests++; if (res_rd[16:0] !== 17'h1FFFF) begin n_fail++; $display("FAIL long_keeps_addr8: got %h exp 1ffff", res_rd[16:0]); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_align();
        wait_pos(9, 0);
        access(1'b0, 1'b0, 5'd9, 35'h0, 1'b0);
        n_tests++; if (res_lat !== 576) begin n_fail++; $display("FAIL align_exact_latency: got %0d exp 576", res_lat); end
        n_tests++; if (res_min !== 9 || res_bit !== 0) begin n_fail++; $display("FAIL align_exact_pos: got %0d/%0d exp 9/0", res_min, res_bit); end
        wait_pos(8, 17);
        access(1'b0, 1'b0, 5'd9, 35'h0, 1'b0);
        n_tests++; if (res_lat !== 1) begin n_fail++; $display("FAIL align_prev_latency: got %0d exp 1", res_lat); end
        n_tests++; if (res_rd[16:0] !== 17'h1FFFF) begin n_fail++; $display("FAIL align_prev_data: got %h exp 1ffff", res_rd[16:0]); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_clear();
        fill = 1'b1;
        step();
        fill = 1'b0;
        access(1'b1, 1'b0, 5'd3, 35'h0, 1'b1);
        n_tests++; if (res_ack !== 1'b1) begin n_fail++; $display("FAIL clr_ack: got %b exp 1", res_ack); end
        n_tests++; if (res_n !== 0) begin n_fail++; $display("FAIL clr_req_ignored: got %0d strobes exp 0", res_n); end
        n_tests++; if (res_zc !== 576) begin n_fail++; $display("FAIL clr_span: got %0d exp 576", res_zc); end
        n_tests++; if (res_zmin !== 0 || res_zbit !== 0) begin n_fail++; $display("FAIL clr_start: got %0d/%0d exp 0/0", res_zmin, res_zbit); end
        n_tests++; if (sr !== '0) begin n_fail++; $display("FAIL clr_tank_zero: got %0d ones exp 0", $countones(sr)); end
        access(1'b0, 1'b0, 5'd0, 35'h0, 1'b0);
        n_tests++; if (res_rd[16:0] !== 17'h0) begin n_fail++; $display("FAIL clr_rd_addr0: got %h exp 0", res_rd[16:0]); end
        access(1'b0, 1'b1, 5'd31, 35'h0, 1'b0);
        n_tests++; if (res_rd !== 35'h0) begin n_fail++; $display("FAIL clr_rd_long30: got %h exp 0", res_rd); end
    endtask

    // ------------------------------------------------------------------------
    // Old word 1FFFF, new word 000C3, reset held during XFER bit 8: bits 0..7
    // carry the new value, bit 8 is forced to 0 by reset, bits 9..16 keep the
    // old ones -> 1FEC3 enters the tank.
    task automatic test_reset_mid_xfer();
        logic [16:0] cap;
        logic [16:0] nw;
        int          p;
        logic        saw_ack;
        access(1'b1, 1'b0, 5'd3, 35'h1FFFF, 1'b0);
        nw = 17'h000C3;
        cap = '0;
        p = -1;
        saw_ack = 1'b0;
        bus.req = 1'b1; bus.we = 1'b1; bus.long_w = 1'b0; bus.addr = 5'd3;
        for (int c = 1; c <= 1300 && p < 17; c++) begin
            step();
            if (c == 1) bus.req = 1'b0;
            if (r1_rst) r1_rst = 1'b0;
            if (p < 0 && bus.wdata_req) p = 0;
            bus.wdata = 1'b1;
            if (p >= 0) begin
                if (bus.wdata_req) bus.wdata = nw[p];
                if (p == 8) r1_rst = 1'b1;
                #1;
                cap[p] = tank_in;
                if (bus.ack) saw_ack = 1'b1;
                if (p == 9 && bus.busy !== 1'b0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rstx_busy_after: got %b exp 0", bus.busy);
                end
                p++;
            end
        end
        n_tests++; if (p !== 17) begin n_fail++; $display("FAIL rstx_timeout: got %0d positions exp 17", p); end
        n_tests++; if (cap !== 17'h1FEC3) begin n_fail++; $display("FAIL rstx_tank_bits: got %h exp 1fec3", cap); end
        for (int c = 0; c < 40; c++) begin
            step();
            #1;
            if (bus.ack) saw_ack = 1'b1;
        end
        n_tests++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL rstx_no_ack: got %b exp 0", saw_ack); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstx_idle: got busy %b exp 0", bus.busy); end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        r1_rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.long_w = 1'b0; bus.addr = '0;
        bus.clr = 1'b0; bus.wdata = 1'b0;
        step();
        step();
        step();
        r1_rst = 1'b0;

        test_reset();
        test_short();
        test_long();
        test_align();
        test_clear();
        test_reset_mid_xfer();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_tank_controller.md
Name: memory_tank_controller

Overview:
Sequencer for one recirculating long tank holding 32 minor cycles × 18 pulse positions, i.e. 576 bit times per major cycle. It tracks tank position with bit and minor-cycle counters and drives the tank input. By default it recirculates the tank output; when a request arrives it waits for the addressed word to emerge, then gates a serial read or write. It sits between the store control and a single delay-line instance such as memory_r1_down_1.

Parameters:
BITS_PER_MINOR, 18, pulse positions per minor cycle (17 data + 1 gap/sandwich)
MINORS, 32, minor cycles per major cycle (tank circulation)
ADDR_W, 5, short-word address width, log2(MINORS)

Ports:
r1_clk  input  1  bit-rate clock; one pulse position per cycle
r1_rst  input  1  synchronous reset, active-high
req  input  1  access request, level; sampled only in IDLE
we  input  1  1 = write, 0 = read; latched with req
long_w  input  1  1 = 35-bit long word, 0 = 17-bit short word; latched with req
addr  input  ADDR_W  short-word location; LSB ignored when long_w=1
clr  input  1  clear-whole-tank request; sampled only in IDLE; priority over req
wdata  input  1  serial write bit, LSB first, consumed when wdata_req=1
tank_out  input  1  bit emerging from the delay line this cycle
tank_in  output  1  bit fed into the delay line
rdata  output  1  serial read bit, valid when rdata_valid=1
rdata_valid  output  1  read bit strobe
wdata_req  output  1  write bit consumed this cycle
busy  output  1  state is not IDLE
ack  output  1  one-cycle completion pulse
minor_sync  output  1  high when bit_cnt==0; used as the monitor strobe
minor_cnt  output  ADDR_W  current minor cycle at the tank output
bit_cnt  output  5  current pulse position, 0..17

Behaviour:
- Reset, sampled on r1_clk: state=IDLE; bit_cnt=0; minor_cnt=0. All 1-bit outputs are 0, so minor_sync is 0 during the reset cycle.
- An access in progress is abandoned on reset with no ack. Tank contents are not touched beyond recirculation forced to 0 while r1_rst=1.
- Counters run free every cycle outside reset:
  - bit_cnt counts 0..17, then wraps to 0.
  - minor_cnt increments when bit_cnt wraps 17→0, and itself wraps 31→0.
- Default path: tank_in = tank_out, pure recirculation with zero added latency.
- States:
  - IDLE:
    - clr=1 → CLEAR, regardless of req.
    - Otherwise req=1 → WAIT, latching we, long_w and tgt. tgt = addr, with tgt[0] forced to 0 if long_w=1.
  - WAIT: no action until the first cycle strictly after the accept cycle with minor_cnt==tgt and bit_cnt==0. That cycle is the first XFER bit.
  - XFER: lasts 17 cycles (short) or 35 cycles (long). A long word covers positions 0..17 of minor tgt and 0..16 of minor tgt+1, LSB first.
    - Write: wdata_req=1, tank_in=wdata.
    - Read: tank_in=tank_out, rdata=tank_out, rdata_valid=1.
    - After the last bit → DONE.
  - CLEAR: waits for minor_cnt==0 and bit_cnt==0 strictly after acceptance. It then forces tank_in=0 for 576 consecutive cycles → DONE.
  - DONE: ack=1 for one cycle → IDLE. A held req is accepted at the earliest on the cycle after ack.
- Worst-case latency from accept to first XFER bit is 576 cycles. This happens when the request is accepted exactly at the matching position.
- req and clr are ignored while busy. addr, we, long_w and clr changes after accept have no effect.
- rdata is 0 when rdata_valid=0.
- wdata is ignored when wdata_req=0.

Test Plan:
- Reset: hold r1_rst 3 cycles mid-count → bit_cnt=0, minor_cnt=0, all 1-bit outputs 0. On the first cycle after release minor_sync=1. The first minor_cnt increment comes 18 cycles later.
- Short write then read at addr=5, data 17'h1A5C3 LSB first:
  - Write: wdata_req high for exactly 17 cycles starting at minor 5, bit 0. ack follows 1 cycle after the last bit.
  - Read one major cycle later: rdata returns 17'h1A5C3 over 17 rdata_valid cycles. Other tank locations are unchanged.
- Long write at addr=7, long_w=1, data 35'h5_A5A5_A5A5: the transfer starts at minor 6 (LSB forced) and spans 35 cycles. A long read at addr=6 returns the identical value.
- Alignment wrap: req accepted exactly at minor 9, bit 0 with addr=9 → first XFER bit 576 cycles after the accept cycle.
- Priority and clear: clr=1 and req=1 in IDLE together → CLEAR is taken and req is ignored. After ack, a read of every address returns 0, and the CLEAR span covers exactly 576 zero cycles.
- Reset mid-XFER: assert r1_rst at bit 8 of a write → no ack, state IDLE. Positions already written keep the new bits; the remaining positions keep the old bits.
